dcache_wb_direct: RTL and testbench

Direct-mapped, write-back, write-allocate data cache. It is the responder on the pipeline's D-cache interface: it accepts the core's read/write requests, answers read hits combinationally and stalls the core on misses. Behind it sits a 128-bit line-wide memory port with a ready handshake. It is located between MIPS core DCACHE_* ports and the memory model.

---
 rtl/dcache_wb_direct_pkg.sv | 44 ++++
 rtl/dcache_wb_direct_if.sv | 35 +++
 rtl/dcache_wb_direct_line_store.sv | 65 ++++++
 rtl/dcache_wb_direct.sv | 123 ++++++++++++
 tb/tb_dcache_wb_direct.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_wb_direct_pkg.sv
// Shared types, widths and address-field helpers for the direct-mapped D-cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  localparam int unsigned WORD_W         = 32;
  localparam int unsigned LINE_W         = 128;
  localparam int unsigned WORDS_PER_LINE = 4;
  localparam int unsigned ADDR_W         = 30;
  localparam int unsigned MEM_ADDR_W     = 28;

  // Word offset within a line
  function automatic logic [1:0] addr_off(input logic [ADDR_W-1:0] a);
    return a[1:0];
  endfunction

  // Line address (word address without the offset)
  function automatic logic [MEM_ADDR_W-1:0] addr_line(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:2];
  endfunction

  // Index field, right-aligned in a line-address-wide result
  function automatic logic [MEM_ADDR_W-1:0] addr_idx(input logic [ADDR_W-1:0] a,
                                                      input int unsigned      idx_w);
    return addr_line(a) & ((MEM_ADDR_W'(1) << idx_w) - MEM_ADDR_W'(1));
  endfunction

  // Tag field, right-aligned in a line-address-wide result
  function automatic logic [MEM_ADDR_W-1:0] addr_tag(input logic [ADDR_W-1:0] a,
                                                      input int unsigned      idx_w);
    return addr_line(a) >> idx_w;
  endfunction

  // Select one word of a line; word 0 lives in bits [31:0]
  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                   input logic [1:0]        off);
    return line[32'(off)*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/dcache_wb_direct_if.sv
// Core-side request/response and memory-side line port of the D-cache.
interface dcache_wb_direct_if;
  import dcache_pkg::*;

  logic                  proc_read;
  logic                  proc_write;
  logic [ADDR_W-1:0]     proc_addr;
  logic [WORD_W-1:0]     proc_wdata;
  logic                  proc_stall;
  logic [WORD_W-1:0]     proc_rdata;

  logic                  mem_read;
  logic                  mem_write;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0]     mem_wdata;
  logic [LINE_W-1:0]     mem_rdata;
  logic                  mem_ready;

  // Cache side
  modport slave (
    input  proc_read, proc_write, proc_addr, proc_wdata,
    output proc_stall, proc_rdata,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  // Core + memory side
  modport master (
    output proc_read, proc_write, proc_addr, proc_wdata,
    input  proc_stall, proc_rdata,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );

endinterface

// File: rtl/dcache_wb_direct_line_store.sv
// Valid/dirty/tag/data arrays with a core read port, a write-back read port,
// a word-write port (sets dirty) and a line-fill port (sets valid, clears dirty).
module dcache_line_store
  import dcache_pkg::*;
#(
  parameter int unsigned NUM_LINES = 8,
  parameter int unsigned IDX_W     = 3,
  parameter int unsigned TAG_W     = 25
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  i_rd_idx,
  output logic              o_rd_valid,
  output logic              o_rd_dirty,
  output logic [TAG_W-1:0]  o_rd_tag,
  output logic [LINE_W-1:0] o_rd_data,
  input  logic [IDX_W-1:0]  i_wb_idx,
  output logic [TAG_W-1:0]  o_wb_tag,
  output logic [LINE_W-1:0] o_wb_data,
  input  logic              i_wr_en,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  logic [1:0]        i_wr_off,
  input  logic [WORD_W-1:0] i_wr_word,
  input  logic              i_fill_en,
  input  logic [IDX_W-1:0]  i_fill_idx,
  input  logic [TAG_W-1:0]  i_fill_tag,
  input  logic [LINE_W-1:0] i_fill_data
);

  logic [NUM_LINES-1:0] r_valid;
  logic [NUM_LINES-1:0] r_dirty;
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [LINE_W-1:0]    r_data [NUM_LINES];

  // Array update: async clear, otherwise line fill or single-word write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_dirty <= '0;
      for (int unsigned i = 0; i < NUM_LINES; i++) begin
        r_tag[i]  <= '0;
        r_data[i] <= '0;
      end
    end else if (i_fill_en) begin
      r_valid[i_fill_idx] <= 1'b1;
      r_dirty[i_fill_idx] <= 1'b0;
      r_tag[i_fill_idx]   <= i_fill_tag;
      r_data[i_fill_idx]  <= i_fill_data;
    end else if (i_wr_en) begin
      r_dirty[i_wr_idx] <= 1'b1;
      r_data[i_wr_idx][32'(i_wr_off)*WORD_W +: WORD_W] <= i_wr_word;
    end
  end

  // Combinational read ports
  always_comb begin
    o_rd_valid = r_valid[i_rd_idx];
    o_rd_dirty = r_dirty[i_rd_idx];
    o_rd_tag   = r_tag[i_rd_idx];
    o_rd_data  = r_data[i_rd_idx];
    o_wb_tag   = r_tag[i_wb_idx];
    o_wb_data  = r_data[i_wb_idx];
  end

endmodule

// File: rtl/dcache_wb_direct.sv
// Direct-mapped write-back, write-allocate D-cache: hit detection, miss FSM,
// miss address latch and memory-port muxing.
module dcache_wb_direct
  import dcache_pkg::*;
#(
  parameter  int unsigned NUM_LINES = 8,
  localparam int unsigned IDX_W     = $clog2(NUM_LINES),
  localparam int unsigned TAG_W     = MEM_ADDR_W - IDX_W
) (
  input logic              clk,
  input logic              rst_n,
  dcache_wb_direct_if.slave bus
);

  state_t                r_state;
  state_t                w_next;
  logic [MEM_ADDR_W-1:0] r_miss_addr;

  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic [1:0]        w_off;
  logic [IDX_W-1:0]  w_miss_idx;
  logic [TAG_W-1:0]  w_miss_tag;
  logic              w_rd_valid;
  logic              w_rd_dirty;
  logic [TAG_W-1:0]  w_rd_tag;
  logic [LINE_W-1:0] w_rd_data;
  logic [TAG_W-1:0]  w_wb_tag;
  logic [LINE_W-1:0] w_wb_data;
  logic              w_req;
  logic              w_hit;
  logic              w_idle;
  logic              w_miss;
  logic              w_wr_en;
  logic              w_fill_en;

  // Address decode and hit/miss qualification
  always_comb begin
    w_idx      = IDX_W'(addr_idx(bus.proc_addr, IDX_W));
    w_tag      = TAG_W'(addr_tag(bus.proc_addr, IDX_W));
    w_off      = addr_off(bus.proc_addr);
    w_miss_idx = r_miss_addr[IDX_W-1:0];
    w_miss_tag = r_miss_addr[MEM_ADDR_W-1:IDX_W];
    w_req      = bus.proc_read | bus.proc_write;
    w_hit      = w_rd_valid & (w_rd_tag == w_tag);
    w_idle     = (r_state == IDLE);
    w_miss     = w_idle & w_req & ~w_hit;
    w_wr_en    = w_idle & bus.proc_write & w_hit;
    w_fill_en  = (r_state == ALLOCATE) & bus.mem_ready;
  end

  dcache_line_store #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_store (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rd_idx    (w_idx),
    .o_rd_valid  (w_rd_valid),
    .o_rd_dirty  (w_rd_dirty),
    .o_rd_tag    (w_rd_tag),
    .o_rd_data   (w_rd_data),
    .i_wb_idx    (w_miss_idx),
    .o_wb_tag    (w_wb_tag),
    .o_wb_data   (w_wb_data),
    .i_wr_en     (w_wr_en),
    .i_wr_idx    (w_idx),
    .i_wr_off    (w_off),
    .i_wr_word   (bus.proc_wdata),
    .i_fill_en   (w_fill_en),
    .i_fill_idx  (w_miss_idx),
    .i_fill_tag  (w_miss_tag),
    .i_fill_data (bus.mem_rdata)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Miss address latch; the rest of the miss runs from this copy so a
  // dropped core request still completes the fill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_miss_addr <= '0;
    else if (w_miss) r_miss_addr <= addr_line(bus.proc_addr);
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (w_miss) w_next = (w_rd_valid & w_rd_dirty) ? WRITEBACK : ALLOCATE;
      WRITEBACK: if (bus.mem_ready) w_next = ALLOCATE;
      ALLOCATE:  if (bus.mem_ready) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  // Outputs: memory requests decode from the state register only
  always_comb begin
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.proc_stall = w_req & ~(w_idle & w_hit);
    bus.proc_rdata = line_word(w_rd_data, w_off);
    case (r_state)
      WRITEBACK: begin
        bus.mem_write = 1'b1;
        bus.mem_addr  = {w_wb_tag, w_miss_idx};
        bus.mem_wdata = w_wb_data;
      end
      ALLOCATE: begin
        bus.mem_read = 1'b1;
        bus.mem_addr = r_miss_addr;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dcache_wb_direct.sv
// Self-checking bench for dcache_wb_direct against a line-level cache model.
module tb_dcache_wb_direct;
  import dcache_pkg::*;

  localparam int unsigned NL = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  dcache_wb_direct_if bus ();

  dcache_wb_direct #(.NUM_LINES(NL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference model: cache contents per line and a sparse backing memory
  bit           m_valid [NL];
  bit           m_dirty [NL];
  int unsigned  m_tag   [NL];
  logic [127:0] m_data  [NL];
  logic [127:0] mem_m   [int unsigned];

  function automatic void model_reset();
    for (int i = 0; i < NL; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = 0;
      m_data[i]  = '0;
    end
  endfunction

  function automatic logic [127:0] mem_get(int unsigned la);
    logic [127:0] v;
    if (mem_m.exists(la)) return mem_m[la];
    for (int unsigned w = 0; w < 4; w++)
      v[w*32 +: 32] = (la << 8) ^ (w * 32'h1111_0101) ^ 32'hA5C3_0000;
    return v;
  endfunction

  function automatic logic [31:0] word_of(logic [127:0] line, int unsigned off);
    logic [127:0] t;
    t = line >> (off * 32);
    return t[31:0];
  endfunction

  function automatic logic [127:0] put_word(logic [127:0] line, int unsigned off,
                                            logic [31:0] wd);
    logic [127:0] m;
    m = 128'hFFFF_FFFF << (off * 32);
    return (line & ~m) | ({96'd0, wd} << (off * 32));
  endfunction

  // One core access from presentation through the hit cycle; memory answers
  // each miss phase after lat extra cycles. Ends at the hit cycle (+1 ns).
  task automatic run_access(input bit rd, input bit wr, input int unsigned a,
                            input logic [31:0] wd, input int unsigned lat,
                            input string nm);
    int unsigned  la, off, idx, tg, wb_la;
    logic [127:0] fill, wbl;
    la  = a / 4;
    off = a % 4;
    idx = la % NL;
    tg  = la / NL;
    @(negedge clk);
    bus.proc_read  = rd;
    bus.proc_write = wr;
    bus.proc_addr  = 30'(a);
    bus.proc_wdata = wd;
    #1;
    if (!(m_valid[idx] && m_tag[idx] == tg)) begin
      n_tests++;
      if (bus.proc_stall !== 1'b1) begin
        n_fail++; $display("FAIL %s miss_stall: got %b want 1", nm, bus.proc_stall);
      end
      if (m_valid[idx] && m_dirty[idx]) begin
        wb_la = m_tag[idx] * NL + idx;
        wbl   = m_data[idx];
        for (int unsigned c = 0; c <= lat; c++) begin
          @(negedge clk);
          bus.mem_ready = (c == lat);
          #1;
          n_tests++;
          if ({bus.mem_write, bus.mem_read, bus.proc_stall} !== 3'b101) begin
            n_fail++;
            $display("FAIL %s wb_ctl[%0d]: got w/r/stall=%b%b%b want 101", nm, c,
                     bus.mem_write, bus.mem_read, bus.proc_stall);
          end
          n_tests++;
          if (bus.mem_addr !== 28'(wb_la)) begin
            n_fail++; $display("FAIL %s wb_addr[%0d]: got %h want %h", nm, c, bus.mem_addr, 28'(wb_la));
          end
          n_tests++;
          if (bus.mem_wdata !== wbl) begin
            n_fail++; $display("FAIL %s wb_data[%0d]: got %h want %h", nm, c, bus.mem_wdata, wbl);
          end
        end
        mem_m[wb_la] = wbl;
      end
      fill = mem_get(la);
      for (int unsigned c = 0; c <= lat; c++) begin
        @(negedge clk);
        bus.mem_ready = (c == lat);
        bus.mem_rdata = fill;
        #1;
        n_tests++;
        if ({bus.mem_read, bus.mem_write, bus.proc_stall} !== 3'b101) begin
          n_fail++;
          $display("FAIL %s alloc_ctl[%0d]: got r/w/stall=%b%b%b want 101", nm, c,
                   bus.mem_read, bus.mem_write, bus.proc_stall);
        end
        n_tests++;
        if (bus.mem_addr !== 28'(la)) begin
          n_fail++; $display("FAIL %s alloc_addr[%0d]: got %h want %h", nm, c, bus.mem_addr, 28'(la));
        end
        n_tests++;
        if (bus.proc_rdata !== word_of(m_data[idx], off)) begin
          n_fail++;
          $display("FAIL %s early_update[%0d]: got %h want %h", nm, c, bus.proc_rdata,
                   word_of(m_data[idx], off));
        end
      end
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = tg;
      m_data[idx]  = fill;
      @(negedge clk);
      bus.mem_ready = 1'b0;
      bus.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      #1;
    end
    n_tests++;
    if ({bus.proc_stall, bus.mem_read, bus.mem_write} !== 3'b000) begin
      n_fail++;
      $display("FAIL %s hit_ctl: got stall/r/w=%b%b%b want 000", nm,
               bus.proc_stall, bus.mem_read, bus.mem_write);
    end
    n_tests++;
    if (bus.mem_addr !== 28'd0 || bus.mem_wdata !== 128'd0) begin
      n_fail++; $display("FAIL %s idle_mem_bus: got addr %h wdata %h want 0", nm, bus.mem_addr, bus.mem_wdata);
    end
    if (!wr) begin
      n_tests++;
      if (bus.proc_rdata !== word_of(m_data[idx], off)) begin
        n_fail++; $display("FAIL %s rdata: got %h want %h", nm, bus.proc_rdata, word_of(m_data[idx], off));
      end
    end else begin
      m_data[idx]  = put_word(m_data[idx], off, wd);
      m_dirty[idx] = 1'b1;
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    bus.proc_read  = 1'b0;
    bus.proc_write = 1'b0;
  endtask

  task automatic test_reset();
    bus.proc_read  = 1'b0;
    bus.proc_write = 1'b0;
    bus.proc_addr  = '0;
    bus.proc_wdata = '0;
    bus.mem_ready  = 1'b0;
    bus.mem_rdata  = '0;
    rst_n = 1'b0;
    model_reset();
    #2;
    n_tests++;
    if ({bus.proc_stall, bus.mem_read, bus.mem_write} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctl: got stall/r/w=%b%b%b want 000", bus.proc_stall, bus.mem_read, bus.mem_write);
    end
    n_tests++;
    if (bus.proc_rdata !== 32'd0 || bus.mem_addr !== 28'd0 || bus.mem_wdata !== 128'd0) begin
      n_fail++;
      $display("FAIL reset_data: got rdata %h addr %h wdata %h want 0", bus.proc_rdata, bus.mem_addr, bus.mem_wdata);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_cold_miss();
    mem_m[4] = {32'hDDDD, 32'hCCCC, 32'hBBBB, 32'hAAAA};
    run_access(1'b1, 1'b0, 32'h10, 32'd0, 3, "cold_miss");
    n_tests++;
    if (bus.proc_rdata !== 32'hAAAA) begin
      n_fail++; $display("FAIL cold_miss_word0: got %h want 0000aaaa", bus.proc_rdata);
    end
    go_idle();
  endtask

  task automatic test_read_hit();
    run_access(1'b1, 1'b0, 32'h12, 32'd0, 0, "read_hit");
    n_tests++;
    if (bus.proc_rdata !== 32'hCCCC || bus.proc_stall !== 1'b0) begin
      n_fail++; $display("FAIL read_hit_word2: got %h stall %b want 0000cccc stall 0", bus.proc_rdata, bus.proc_stall);
    end
    go_idle();
  endtask

  task automatic test_write_hit();
    run_access(1'b0, 1'b1, 32'h11, 32'h1234_5678, 0, "write_hit");
    run_access(1'b1, 1'b0, 32'h11, 32'd0, 0, "write_hit_rb");
    n_tests++;
    if (bus.proc_rdata !== 32'h1234_5678) begin
      n_fail++; $display("FAIL write_hit_readback: got %h want 12345678", bus.proc_rdata);
    end
    go_idle();
  endtask

  task automatic test_dirty_conflict();
    run_access(1'b1, 1'b0, 32'h30, 32'd0, 2, "dirty_conflict");
    n_tests++;
    if (!mem_m.exists(4) || mem_m[4] !== {32'hDDDD, 32'hCCCC, 32'h1234_5678, 32'hAAAA}) begin
      n_fail++; $display("FAIL dirty_conflict_wb_line: model memory line 4 not written back as expected");
    end
    go_idle();
  endtask

  task automatic test_slow_memory();
    run_access(1'b1, 1'b0, 32'h50, 32'd0, 10, "slow_memory");
    go_idle();
  endtask

  task automatic test_idle_ready_ignored();
    @(negedge clk);
    bus.mem_ready = 1'b1;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #1;
    n_tests++;
    if ({bus.mem_read, bus.mem_write, bus.proc_stall} !== 3'b000) begin
      n_fail++; $display("FAIL idle_ready: got r/w/stall=%b%b%b want 000", bus.mem_read, bus.mem_write, bus.proc_stall);
    end
    run_access(1'b1, 1'b0, 32'h53, 32'd0, 0, "idle_ready_hit");
    go_idle();
  endtask

  task automatic test_reset_mid_miss();
    @(negedge clk);
    bus.proc_read = 1'b1;
    bus.proc_addr = 30'h10;
    @(negedge clk);
    #1;
    n_tests++;
    if (bus.mem_read !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_alloc1: got mem_read %b want 1", bus.mem_read);
    end
    @(negedge clk);
    #1;
    n_tests++;
    if (bus.mem_read !== 1'b1 || bus.mem_addr !== 28'h4) begin
      n_fail++; $display("FAIL rst_mid_alloc2: got mem_read %b addr %h want 1 4", bus.mem_read, bus.mem_addr);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.mem_read, bus.mem_write} !== 2'b00 || bus.mem_addr !== 28'd0) begin
      n_fail++; $display("FAIL rst_mid_drop: got r/w=%b%b addr %h want 00 0", bus.mem_read, bus.mem_write, bus.mem_addr);
    end
    n_tests++;
    if (bus.proc_rdata !== 32'd0) begin
      n_fail++; $display("FAIL rst_mid_cleared: got rdata %h want 0", bus.proc_rdata);
    end
    model_reset();
    @(negedge clk);
    bus.proc_read = 1'b0;
    rst_n = 1'b1;
    run_access(1'b1, 1'b0, 32'h10, 32'd0, 1, "rst_refill");
    run_access(1'b1, 1'b0, 32'h0C, 32'd0, 0, "rst_other_line");
    go_idle();
  endtask

  task automatic test_random();
    int unsigned tg, idx, off, op, lat, a;
    for (int n = 0; n < 80; n++) begin
      tg  = $urandom_range(0, 3);
      idx = $urandom_range(0, NL - 1);
      off = $urandom_range(0, 3);
      op  = $urandom_range(0, 4);
      lat = $urandom_range(0, 3);
      a   = (tg * NL + idx) * 4 + off;
      run_access(op != 2 && op != 3, op >= 2, a, $urandom, lat, "random");
      if ($urandom_range(0, 3) == 0) go_idle();
    end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_read_hit();
    test_write_hit();
    test_dirty_conflict();
    test_slow_memory();
    test_idle_ready_ignored();
    test_reset_mid_miss();
    test_random();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
